// File: rtl/approx_div_pkg.sv
// Shared constants and types for the approximate divider and its leading-one
// detector.
package approx_div_pkg;

  localparam int NUM = 6;        // retained significant bits per operand
  localparam int MW  = 2 * NUM;  // quotient mantissa width
  localparam int CW  = 4;        // iteration counter width
  localparam int EW  = 5;        // operand exponent width (0..26)

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DIV,
    SHIFT,
    DONE
  } state_t;

  // Right shift that keeps only the top NUM significant bits below index idx.
  function automatic logic [EW-1:0] trunc_exp(input logic [4:0] idx);
    if (int'(idx) >= NUM) return EW'(int'(idx) - NUM + 1);
    else return '0;
  endfunction

endpackage

// File: rtl/lod_32.sv
// Combinational 32-bit leading-one detector: index of the highest set bit
// (0 when the word is zero) plus a zero flag.
module lod_32 (
  input  logic [31:0] x,
  output logic [4:0]  idx,
  output logic        zero
);

  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves
    // it unassigned, which would infer a latch.
    idx  = '0;
    zero = (x == '0);
    for (int i = 0; i < 32; i++) begin
      if (x[i]) idx = 5'(i);
    end
  end

endmodule

// File: rtl/approx_div_32.sv
// Sequential approximate 32-bit unsigned divider: leading-one truncation to
// NUM-bit mantissas, restoring divide one bit per cycle, exponent rescale.
module approx_div_32
  import approx_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic        div_by_zero
);

  state_t          state, state_nx;
  logic [31:0]     a_r, b_r;
  logic [NUM-1:0]  ma, mb, rem;
  logic [EW-1:0]   ea, eb;
  logic            bz;
  logic [MW-1:0]   dvd, qm;
  logic [CW-1:0]   cnt;

  logic [4:0]      ka, lb;
  logic            za, zb;
  logic [EW-1:0]   ea_c, eb_c;
  logic [NUM-1:0]  ma_c, mb_c;

  lod_32 u_lod_a (.x(a_r), .idx(ka), .zero(za));
  lod_32 u_lod_b (.x(b_r), .idx(lb), .zero(zb));

  assign ea_c = trunc_exp(ka);
  assign eb_c = trunc_exp(lb);
  assign ma_c = za ? '0 : NUM'(a_r >> ea_c);
  assign mb_c = NUM'(b_r >> eb_c);

  // One restoring-division step: bring down the next dividend bit, subtract
  // the divisor when it fits.
  logic [NUM:0]    rem_try, rem_sub;
  logic            fits;

  assign rem_try = {rem, dvd[MW-1]};
  assign fits    = (rem_try >= {1'b0, mb});
  assign rem_sub = rem_try - {1'b0, mb};

  // Rescale by sh = ea - eb - NUM; the right-shift amount reaches 32 when a
  // tiny dividend meets a full-width divisor, which correctly yields 0.
  logic signed [EW+1:0] sh;
  logic [EW+1:0]        rsh;
  logic [31:0]          q_shf;

  always_comb begin
    sh    = $signed((EW+2)'(ea)) - $signed((EW+2)'(eb)) - $signed((EW+2)'(NUM));
    rsh   = -sh;
    q_shf = sh[EW+1] ? (32'(qm) >> rsh) : (32'(qm) << sh);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = NORM;
      // Divide-by-zero bypasses DIV but still passes through SHIFT, where the
      // saturated result is registered.
      NORM:  state_nx = zb ? SHIFT : DIV;
      DIV:   if (cnt == CW'(MW - 1)) state_nx = SHIFT;
      SHIFT: state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      ma          <= '0;
      mb          <= '0;
      ea          <= '0;
      eb          <= '0;
      bz          <= 1'b0;
      dvd         <= '0;
      rem         <= '0;
      qm          <= '0;
      cnt         <= '0;
      q           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
        end
        NORM: begin
          ma  <= ma_c;
          mb  <= mb_c;
          ea  <= ea_c;
          eb  <= eb_c;
          bz  <= zb;
          dvd <= {ma_c, {NUM{1'b0}}};
          rem <= '0;
          qm  <= '0;
          cnt <= '0;
        end
        DIV: begin
          rem <= fits ? rem_sub[NUM-1:0] : rem_try[NUM-1:0];
          qm  <= {qm[MW-2:0], fits};
          dvd <= {dvd[MW-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        SHIFT: begin
          q           <= bz ? 32'hFFFF_FFFF : q_shf;
          div_by_zero <= bz;
        end
        default: ;
      endcase
    end
  end

endmodule
